serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//  Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.
//  Each bit is one full-subtractor step (half-subtractor pair) with a registered borrow.
//  It is the subtract-direction counterpart of the mux-based adder cells.
//  Used by the arithmetic datapath where area matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32.
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      asynchronous, active-high reset
//  start       in   1      request; sampled only while busy=0
//  a           in   WIDTH  minuend; captured on the accepted start
//  b           in   WIDTH  subtrahend; captured on the accepted start
//  busy        out  1      high while state=SHIFT
//  done        out  1      one-cycle pulse when diff/borrow_out are valid
//  diff        out  WIDTH  a - b mod 2^WIDTH; held until the next accepted start
//  borrow_out  out  1      1 when a < b (unsigned); held with diff
// BEHAVIOUR
//  Reset:
//   - rst asserts asynchronously and is honoured at any time, including mid-operation.
//   - On rst: state=IDLE; busy=0, done=0, diff=0, borrow_out=0; borrow reg=0; count=0.
//   - The in-flight operation is discarded.
//  FSM: IDLE, SHIFT, DONE.
//   - IDLE:  start=1 -> capture a into sa and b into sb, borrow=0, count=0, go to SHIFT.
//   - SHIFT: each cycle, with x=sa[0], y=sb[0], bi=borrow:
//     - d  = x ^ y ^ bi
//     - bo = (~x & y) | (~(x ^ y) & bi)
//     - sa and sb shift right by 1; d shifts into the MSB of the result shift register.
//     - borrow <= bo; count increments.
//     - When count == WIDTH-1 on the processing edge, go to DONE.
//   - DONE:
//     - diff = result register, borrow_out = final borrow, done=1 for this cycle only.
//     - start=1 -> behaves as IDLE+start (captures new operands, goes to SHIFT).
//     - Otherwise go to IDLE.
//  Timing:
//   - start accepted at edge N.
//   - WIDTH processing edges follow.
//   - done is high in the cycle after edge N+WIDTH.
//   - Latency is WIDTH+1 cycles from start to done.
//   - Back-to-back throughput: one result per WIDTH+1 cycles.
//  Handshake / boundaries:
//   - start while busy=1 is ignored and has no side effects.
//   - a/b may change freely after the accepted start; only the captured copies are used.
//   - diff and borrow_out update only in the DONE cycle and stay stable otherwise,
//     including while a new operation is in SHIFT.
//   - done and busy are never high together.
//   - Counter width is $clog2(WIDTH); it wraps only via reload on start.
//   - Unsigned wrap: borrow_out=1 and diff = 2^WIDTH + a - b.
//   - All outputs are registered; there are no combinational paths from inputs to outputs.
// TESTING (WIDTH=8)
//  1. a=0x5A, b=0x1F, start pulse -> busy for 8 cycles; done 9 cycles after start; diff=0x3B, borrow_out=0.
//  2. a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0x80, b=0x80 -> diff=0x00, borrow_out=0.
//  3. start=1 held continuously, a=0x10, b=0x01, then change a/b every cycle
//     -> results are 0x0F, then the next captured pair; done every 9 cycles; mid-SHIFT starts ignored.
//  4. rst asserted 4 cycles into SHIFT -> all outputs 0 immediately (async);
//     a new start after release completes correctly (0xC8-0x64=0x64).
//  5. Random 1000 operand pairs against a golden {borrow,diff} = {a<b, a-b}; check done/busy exclusivity.
//  6. Exhaustive 256x256 sweep at WIDTH=8 plus a WIDTH=2 build sweep; zero mismatches required.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtractor step per clock.
// Registered borrow; diff/borrow_out held until the next completed operation.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    s_idle,
    s_shift,
    s_done
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sa, sb;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_full;
  logic [CW-1:0]    cnt;
  logic             bw;
  logic             x, y, d, bo;
  logic             last;
  logic             load;

  assign x        = sa[0];
  assign y        = sb[0];
  assign d        = x ^ y ^ bw;
  assign bo       = (~x & y) | (~(x ^ y) & bw);
  assign res_full = {d, res};
  assign last     = (cnt == CW'(WIDTH - 1));
  assign load     = start && (state != s_shift);

  // next-state selection
  always_comb begin
    state_nx = state;
    unique case (state)
      s_idle:  if (start) state_nx = s_shift;
      s_shift: if (last) state_nx = s_done;
      s_done:  state_nx = start ? s_shift : s_idle;
      default: state_nx = s_idle;
    endcase
  end

  // state register with registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= s_idle;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == s_shift);
      done  <= (state_nx == s_done);
    end
  end

  // operand capture, serial step and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa         <= '0;
      sb         <= '0;
      res        <= '0;
      bw         <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (load) begin
      sa  <= a;
      sb  <= b;
      bw  <= 1'b0;
      cnt <= '0;
    end else if (state == s_shift) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= res_full[WIDTH-1:1];
      bw  <= bo;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff       <= res_full;
        borrow_out <= bo;
      end
    end
  end

endmodule
